// File: rtl/i2c_slave_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_slave_datapath: oversampled I2C target, 7-bit address, byte RX/TX.   |
// | Optional: I2C_SLAVE_GENERAL_CALL_EN also ACKs general call (8'h00).      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_slave_datapath #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_out,
  input  logic [7:0] data_in,
  output logic       data_req,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       rw,
  output logic       busy
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GEN_CALL_EN = 1'b1;
`else
  localparam bit GEN_CALL_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDRESS   = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_RX_DATA   = 3'd3;
  localparam logic [2:0] S_RX_ACK    = 3'd4;
  localparam logic [2:0] S_TX_DATA   = 3'd5;
  localparam logic [2:0] S_TX_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       phase_q, phase_d;
  logic       sda_out_q, sda_out_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       data_req_q, data_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic       addr_match, gen_call;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high in both samples so an SDA change alongside an SCL edge is data
  assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign rx_byte    = {shift_q, sda_s};
  assign addr_match = (rx_byte[7:1] == SLAVE_ADDR);
  assign gen_call   = GEN_CALL_EN && (rx_byte == 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= 7'd0;
      phase_q    <= 1'b0;
      sda_out_q  <= 1'b1;
      data_out_q <= 8'd0;
      valid_q    <= 1'b0;
      data_req_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      sda_out_q  <= sda_out_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      data_req_q <= data_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[0], SCL_in};
    sda_sync_d = {sda_sync_q[0], SDA_in};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    sda_out_d  = sda_out_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    data_req_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (stop_det) begin
      state_d   = S_IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDRESS;
      bit_cnt_d = 3'd7;
      sda_out_d = 1'b1;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDRESS: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (bit_cnt_q == 3'd0) begin
              if (addr_match || gen_call) begin
                rw_d       = rx_byte[0];
                data_req_d = rx_byte[0];
                busy_d     = 1'b1;
                phase_d    = 1'b0;
                state_d    = S_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        // phase_q=0: next fall starts the ACK bit; phase_q=1: next fall ends it
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_out_d = 1'b0;
              phase_d   = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd7;
              if (rw_q) begin
                shift_d   = data_in[6:0];
                sda_out_d = data_in[7];
                state_d   = S_TX_DATA;
              end else begin
                sda_out_d = 1'b1;
                state_d   = S_RX_DATA;
              end
            end
          end
        end
        S_RX_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (bit_cnt_q == 3'd0) begin
              data_out_d = rx_byte;
              valid_d    = 1'b1;
              phase_d    = 1'b0;
              state_d    = S_RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_out_d = 1'b0;
              phase_d   = 1'b1;
            end else begin
              sda_out_d = 1'b1;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd7;
              state_d   = S_RX_DATA;
            end
          end
        end
        S_TX_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_out_d = 1'b1;
              phase_d   = 1'b0;
              state_d   = S_TX_ACK;
            end else begin
              sda_out_d = shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (!phase_q && scl_rise) begin
            if (!sda_s) begin
              data_req_d = 1'b1;
              phase_d    = 1'b1;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end else if (phase_q && scl_fall) begin
            shift_d   = data_in[6:0];
            sda_out_d = data_in[7];
            bit_cnt_d = 3'd7;
            phase_d   = 1'b0;
            state_d   = S_TX_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    SDA_out  = sda_out_q;
    data_out = data_out_q;
    valid    = valid_q;
    data_req = data_req_q;
    rw       = rw_q;
    busy     = busy_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_datapath.sv
`default_nettype none
// Directed bench for i2c_slave_datapath: a bit-level I2C master drives the bus.
module tb_i2c_slave_datapath;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       SDA_out, data_req, valid, rw, busy;
  logic [7:0] data_out;
  logic       sda_bus;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int req_cnt = 0;
  int low_cnt = 0;

  assign sda_bus = sda_m & SDA_out;

  i2c_slave_datapath #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .SCL_in(scl_m), .SDA_in(sda_bus), .SDA_out(SDA_out),
    .data_in(data_in), .data_req(data_req), .data_out(data_out), .valid(valid),
    .rw(rw), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (data_req === 1'b1) req_cnt <= req_cnt + 1;
    if (SDA_out === 1'b0) low_cnt <= low_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(2);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    b = sda_bus; wait_clks(Q);
    scl_m = 1'b0; wait_clks(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_in);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bt);
      d[i] = bt;
    end
    data_in = next_in;
    send_bit(nack);
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++; if (SDA_out !== 1'b1) begin errors++; $display("FAIL reset_sda_out got %b want 1", SDA_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_data_req got %b want 0", data_req); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", rw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_write();
    logic ack;
    int v0;
    v0 = valid_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy); end
    write_byte(8'h3C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack got %b want 0", ack); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL wr_data_out got %h want 3c", data_out); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL wr_valid_cycles got %0d want 1", valid_cnt - v0); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL wr_rw got %b want 0", rw); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int v0, r0, l0;
    v0 = valid_cnt; r0 = req_cnt; l0 = low_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_addr_ack got %b want 1", ack); end
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_data_ack got %b want 1", ack); end
    bus_stop();
    checks++; if (low_cnt - l0 !== 0) begin errors++; $display("FAIL mm_sda_low_cycles got %0d want 0", low_cnt - l0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL mm_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (req_cnt - r0 !== 0) begin errors++; $display("FAIL mm_data_req got %0d want 0", req_cnt - r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got %b want 0", busy); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL mm_data_out got %h want 3c", data_out); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int r0;
    r0 = req_cnt;
    data_in = 8'h96;
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rd_rw got %b want 1", rw); end
    read_byte(d, 1'b0, 8'h5A);
    checks++; if (d !== 8'h96) begin errors++; $display("FAIL rd_byte0 got %h want 96", d); end
    read_byte(d, 1'b1, 8'hFF);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd_byte1 got %h want 5a", d); end
    checks++; if (req_cnt - r0 !== 2) begin errors++; $display("FAIL rd_req_cycles got %0d want 2", req_cnt - r0); end
    wait_clks(Q);
    checks++; if (SDA_out !== 1'b1) begin errors++; $display("FAIL rd_release_after_nack got %b want 1", SDA_out); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d;
    int r0;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h11, ack);
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL rs_data_out got %h want 11", data_out); end
    data_in = 8'hC3;
    r0 = req_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b want 0", ack); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rs_rw got %b want 1", rw); end
    checks++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL rs_req_cycles got %0d want 1", req_cnt - r0); end
    read_byte(d, 1'b1, 8'h00);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rs_read_byte got %h want c3", d); end
    bus_stop();
  endtask

  task automatic recover_bus();
    scl_m = 1'b0; wait_clks(Q);
    bus_stop();
  endtask

  task automatic test_reset_mid();
    logic ack;
    bus_start();
    write_byte(8'hA0, ack);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    #3 reset = 1'b1;
    #1;
    checks++; if (SDA_out !== 1'b1) begin errors++; $display("FAIL rm_bit4_sda got %b want 1", SDA_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_bit4_busy got %b want 0", busy); end
    wait_clks(2);
    reset = 1'b0;
    recover_bus();
    // Second reset lands inside the ACK clock while the target is pulling SDA low
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    checks++; if (SDA_out !== 1'b0) begin errors++; $display("FAIL rm_ack_drive got %b want 0", SDA_out); end
    #3 reset = 1'b1;
    #1;
    checks++; if (SDA_out !== 1'b1) begin errors++; $display("FAIL rm_ack_async_release got %b want 1", SDA_out); end
    wait_clks(2);
    reset = 1'b0;
    recover_bus();
    bus_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_after_addr_ack got %b want 0", ack); end
    write_byte(8'h7E, ack);
    checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL rm_after_data_out got %h want 7e", data_out); end
    bus_stop();
  endtask

  task automatic test_general_call();
    logic ack;
    bus_start();
    write_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL gc_addr_ack got %b want 0", ack); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL gc_rw got %b want 0", rw); end
    write_byte(8'h42, ack);
    checks++; if (data_out !== 8'h42) begin errors++; $display("FAIL gc_data_out got %h want 42", data_out); end
`else
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL gc_addr_ack got %b want 1", ack); end
    write_byte(8'h42, ack);
    checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL gc_data_out got %h want 7e", data_out); end
`endif
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gc_busy_after_stop got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_reset_mid();
    test_general_call();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
